// File: rtl/spi_three_wire_pkg.sv
// spi_three_wire_pkg: state encoding and default field widths shared by the 3-wire SPI slave and master.
package spi_three_wire_pkg;
   localparam int ADDR_W_DEF = 7;
   localparam int DATA_W_DEF = 8;
   typedef enum logic [2:0] {ST_IDLE, ST_CMD, ST_WR, ST_RD, ST_WAIT_CS} state_t;
   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction
endpackage

// File: rtl/spi_sync_edge.sv
// spi_sync_edge: multi-flop synchronizer with rise/fall pulses taken from the last two synchronized samples.
module spi_sync_edge #(
   parameter int   STAGES  = 2,
   parameter logic RST_VAL = 1'b1
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_d,
   output logic o_q,
   output logic o_rise,
   output logic o_fall
);
   logic [STAGES-1:0] r_sync;
   logic              r_prev;
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_sync <= {STAGES{RST_VAL}};
         r_prev <= RST_VAL;
      end else begin
         r_sync <= {r_sync[STAGES-2:0], i_d};
         r_prev <= r_sync[STAGES-1];
      end
   end
   assign o_q    = r_sync[STAGES-1];
   assign o_rise = o_q & ~r_prev;
   assign o_fall = ~o_q & r_prev;
endmodule

// File: rtl/spi_three_wire_slave.sv
// spi_three_wire_slave: 3-wire SPI register-access slave oversampled on CLK.
// Frame is R/W bit, ADDR_W address bits, DATA_W data bits, all MSB first.
module spi_three_wire_slave
   import spi_three_wire_pkg::*;
#(
   parameter int ADDR_W      = ADDR_W_DEF,
   parameter int DATA_W      = DATA_W_DEF,
   parameter int SYNC_STAGES = 2
) (
   input  logic              CLK,
   input  logic              reset,
   input  logic              SPC,
   input  logic              SCEN,
   input  logic              SDI,
   output logic              SDO,
   output logic              SDO_EN,
   output logic [ADDR_W-1:0] ADDR,
   output logic [DATA_W-1:0] WDATA,
   output logic              WR_STB,
   output logic              RD_STB,
   input  logic [DATA_W-1:0] RDATA,
   output logic              FRAME_ERR,
   output logic              BUSY
);
   localparam int SH_W  = max_int(ADDR_W + 1, DATA_W);
   localparam int CNT_W = $clog2(SH_W + 1);
   localparam logic [CNT_W-1:0] CMD_LAST  = CNT_W'(ADDR_W);
   localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);

   state_t                 r_state, w_state_nx;
   logic [CNT_W-1:0]       r_cnt;
   logic [SH_W-2:0]        r_shift;
   logic [SH_W-1:0]        w_shift_nx;
   logic [DATA_W-1:0]      r_rsh;
   logic [SYNC_STAGES-1:0] r_sdi;
   logic [ADDR_W-1:0]      r_addr;
   logic [DATA_W-1:0]      r_wdata;
   logic                   r_wr_stb, r_rd_stb, r_ferr, r_ld, r_sdo_en;
   logic                   w_spc, w_spc_rise, w_spc_fall, w_cs_n, w_cs_rise, w_cs_fall;
   logic                   w_rise, w_fall, w_in_frame, w_cmd_done, w_wr, w_rd, w_ferr;
   logic [1:0]             w_unused;

   spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_spc (
      .i_clk(CLK), .i_rst(reset), .i_d(SPC), .o_q(w_spc), .o_rise(w_spc_rise), .o_fall(w_spc_fall)
   );
   spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_scen (
      .i_clk(CLK), .i_rst(reset), .i_d(SCEN), .o_q(w_cs_n), .o_rise(w_cs_rise), .o_fall(w_cs_fall)
   );

   assign w_unused   = {w_spc, w_cs_rise};
   // Chip enable dominates: an SPC edge coinciding with SCEN high never counts.
   assign w_rise     = w_spc_rise & ~w_cs_n;
   assign w_fall     = w_spc_fall & ~w_cs_n;
   assign w_in_frame = r_state inside {ST_CMD, ST_WR, ST_RD};
   assign w_shift_nx = {r_shift, r_sdi[SYNC_STAGES-1]};
   assign w_cmd_done = (r_state == ST_CMD) && w_rise && (r_cnt == CMD_LAST);

   always_ff @(posedge CLK) begin
      if (reset) r_state <= ST_IDLE;
      else       r_state <= w_state_nx;
   end

   always_comb begin
      w_state_nx = r_state;
      w_wr       = 1'b0;
      w_rd       = 1'b0;
      w_ferr     = 1'b0;
      if (w_in_frame && w_cs_n) begin
         w_state_nx = ST_IDLE;
         w_ferr     = 1'b1;
      end else begin
         case (r_state)
            ST_IDLE:    if (w_cs_fall) w_state_nx = ST_CMD;
            ST_CMD:     if (w_cmd_done) begin
                           w_state_nx = w_shift_nx[ADDR_W] ? ST_RD : ST_WR;
                           w_rd       = w_shift_nx[ADDR_W];
                        end
            ST_WR:      if (w_rise && r_cnt == DATA_LAST) begin
                           w_state_nx = ST_WAIT_CS;
                           w_wr       = 1'b1;
                        end
            ST_RD:      if (w_rise && r_cnt == DATA_LAST) w_state_nx = ST_WAIT_CS;
            ST_WAIT_CS: if (w_cs_n) w_state_nx = ST_IDLE;
            default:    w_state_nx = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge CLK) begin
      if (reset) begin
         r_sdi    <= '0;
         r_cnt    <= '0;
         r_shift  <= '0;
         r_rsh    <= '0;
         r_addr   <= '0;
         r_wdata  <= '0;
         r_wr_stb <= 1'b0;
         r_rd_stb <= 1'b0;
         r_ferr   <= 1'b0;
         r_ld     <= 1'b0;
         r_sdo_en <= 1'b0;
      end else begin
         r_sdi    <= {r_sdi[SYNC_STAGES-2:0], SDI};
         r_wr_stb <= w_wr;
         r_rd_stb <= w_rd;
         r_ferr   <= w_ferr;
         r_ld     <= r_rd_stb;
         r_cnt    <= (w_state_nx != r_state) ? '0 : (w_in_frame && w_rise) ? r_cnt + 1'b1 : r_cnt;
         if (w_rise && r_state inside {ST_CMD, ST_WR}) r_shift <= w_shift_nx[SH_W-2:0];
         if (w_cmd_done) r_addr <= w_shift_nx[ADDR_W-1:0];
         if (w_wr) r_wdata <= w_shift_nx[DATA_W-1:0];
         // The fall before the first data rise keeps the MSB on SDO; later falls advance it.
         r_rsh    <= r_ld ? RDATA :
                     (w_fall && r_cnt != '0 && r_state == ST_RD) ? {r_rsh[DATA_W-2:0], 1'b0} : r_rsh;
         r_sdo_en <= (w_state_nx == ST_RD) && (r_sdo_en || r_ld);
      end
   end

   assign SDO       = r_rsh[DATA_W-1];
   assign SDO_EN    = r_sdo_en;
   assign ADDR      = r_addr;
   assign WDATA     = r_wdata;
   assign WR_STB    = r_wr_stb;
   assign RD_STB    = r_rd_stb;
   assign FRAME_ERR = r_ferr;
   assign BUSY      = (r_state != ST_IDLE);
endmodule

// File: tb/tb_spi_three_wire_slave.sv
// tb_spi_three_wire_slave: directed frame vectors driven by a bit-banged master, plus reset corner cases.
module tb_spi_three_wire_slave;
   logic       CLK = 1'b0, reset = 1'b1, SPC = 1'b1, SCEN = 1'b1, SDI = 1'b0;
   logic [7:0] RDATA = 8'h00;
   logic       SDO, SDO_EN, WR_STB, RD_STB, FRAME_ERR, BUSY;
   logic [6:0] ADDR;
   logic [7:0] WDATA;
   int         n_chk = 0, n_err = 0;
   int         n_wr = 0, n_rd = 0, n_ferr = 0, n_both = 0, n_long = 0;
   logic [7:0] last_wdata = 8'h00;
   logic       prev_wr = 1'b0, prev_rd = 1'b0, prev_fe = 1'b0;

   typedef struct {
      logic [31:0] bits;
      int          nbits;
      int          hp;
      logic [7:0]  rdata;
      int          exp_wr;
      int          exp_rd;
      int          exp_ferr;
      logic [6:0]  exp_addr;
      logic [7:0]  exp_wdata;
      logic [7:0]  exp_mdata;
   } vec_t;

   vec_t vecs[11];

   spi_three_wire_slave #(.ADDR_W(7), .DATA_W(8), .SYNC_STAGES(2)) dut (
      .CLK(CLK), .reset(reset), .SPC(SPC), .SCEN(SCEN), .SDI(SDI), .SDO(SDO), .SDO_EN(SDO_EN),
      .ADDR(ADDR), .WDATA(WDATA), .WR_STB(WR_STB), .RD_STB(RD_STB), .RDATA(RDATA),
      .FRAME_ERR(FRAME_ERR), .BUSY(BUSY)
   );

   always #5 CLK = ~CLK;

   always @(negedge CLK) begin
      if (WR_STB) begin
         n_wr++;
         last_wdata = WDATA;
      end
      if (RD_STB) n_rd++;
      if (FRAME_ERR) n_ferr++;
      if (WR_STB && RD_STB) n_both++;
      if ((WR_STB && prev_wr) || (RD_STB && prev_rd) || (FRAME_ERR && prev_fe)) n_long++;
      prev_wr = WR_STB;
      prev_rd = RD_STB;
      prev_fe = FRAME_ERR;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic apply(input vec_t v, input int k);
      int         wr0, rd0, fe0, bad;
      logic [7:0] md;
      logic       is_rd;
      wr0   = n_wr;
      rd0   = n_rd;
      fe0   = n_ferr;
      bad   = 0;
      md    = 8'h00;
      is_rd = v.bits[v.nbits-1];
      RDATA = v.rdata;
      SCEN  = 1'b0;
      repeat (v.hp) @(negedge CLK);
      for (int i = 0; i < v.nbits; i++) begin
         SPC = 1'b0;
         SDI = v.bits[v.nbits-1-i];
         repeat (v.hp) @(negedge CLK);
         if (SDO_EN !== (is_rd && i >= 8 && i < 16)) bad++;
         if (i >= 8 && i < 16) md = {md[6:0], SDO};
         SPC = 1'b1;
         repeat (v.hp) @(negedge CLK);
      end
      SCEN = 1'b1;
      repeat (4) @(negedge CLK);
      check($sformatf("v%0d wr_stb count", k), n_wr - wr0, v.exp_wr);
      check($sformatf("v%0d rd_stb count", k), n_rd - rd0, v.exp_rd);
      check($sformatf("v%0d frame_err count", k), n_ferr - fe0, v.exp_ferr);
      check($sformatf("v%0d addr", k), ADDR, v.exp_addr);
      check($sformatf("v%0d busy after frame", k), BUSY, 0);
      check($sformatf("v%0d sdo_en after frame", k), SDO_EN, 0);
      check($sformatf("v%0d sdo_en phase errors", k), bad, 0);
      if (v.exp_wr != 0) check($sformatf("v%0d wdata", k), last_wdata, v.exp_wdata);
      if (v.exp_rd != 0 && v.exp_ferr == 0) check($sformatf("v%0d master read data", k), md, v.exp_mdata);
   endtask

   task automatic reset_mid_frame();
      int         wr0, rd0, fe0;
      logic [4:0] b;
      b    = 5'b10110;
      SCEN = 1'b0;
      repeat (5) @(negedge CLK);
      for (int i = 0; i < 5; i++) begin
         SPC = 1'b0;
         SDI = b[4-i];
         repeat (5) @(negedge CLK);
         SPC = 1'b1;
         repeat (5) @(negedge CLK);
      end
      wr0   = n_wr;
      rd0   = n_rd;
      fe0   = n_ferr;
      reset = 1'b1;
      SCEN  = 1'b1;
      repeat (3) @(negedge CLK);
      check("rst addr", ADDR, 0);
      check("rst wdata", WDATA, 0);
      check("rst busy", BUSY, 0);
      check("rst sdo/sdo_en", {SDO, SDO_EN}, 0);
      reset = 1'b0;
      repeat (6) @(negedge CLK);
      check("rst no frame_err", n_ferr - fe0, 0);
      check("rst no strobes", (n_wr - wr0) + (n_rd - rd0), 0);
      check("rst idle after release", BUSY, 0);
   endtask

   initial begin
      vecs[0]  = '{32'h000015A5, 16, 5, 8'h00, 1, 0, 0, 7'h15, 8'hA5, 8'h00};
      vecs[1]  = '{32'h0000FF00, 16, 5, 8'h3C, 0, 1, 0, 7'h7F, 8'h00, 8'h3C};
      vecs[2]  = '{32'h0000033F, 12, 5, 8'h00, 0, 0, 1, 7'h33, 8'h00, 8'h00};
      vecs[3]  = '{32'h00000C69, 16, 5, 8'h00, 1, 0, 0, 7'h0C, 8'h69, 8'h00};
      vecs[4]  = '{32'h000015AF, 20, 5, 8'h00, 1, 0, 0, 7'h01, 8'h5A, 8'h00};
      vecs[5]  = '{32'h0000D500, 16, 5, 8'hE7, 0, 1, 0, 7'h55, 8'h00, 8'hE7};
      vecs[6]  = '{32'h00000288, 10, 5, 8'h99, 0, 1, 1, 7'h22, 8'h00, 8'h00};
      vecs[7]  = '{32'h000040C3, 16, 4, 8'h00, 1, 0, 0, 7'h40, 8'hC3, 8'h00};
      vecs[8]  = '{32'h0000AA00, 16, 4, 8'h81, 0, 1, 0, 7'h2A, 8'h00, 8'h81};
      vecs[9]  = '{32'h00007F00, 16, 4, 8'h00, 1, 0, 0, 7'h7F, 8'h00, 8'h00};
      vecs[10] = '{32'h00008000, 16, 4, 8'hFF, 0, 1, 0, 7'h00, 8'h00, 8'hFF};
      repeat (4) @(negedge CLK);
      check("reset addr", ADDR, 0);
      check("reset wdata", WDATA, 0);
      check("reset strobes", {WR_STB, RD_STB, FRAME_ERR}, 0);
      check("reset sdo/sdo_en/busy", {SDO, SDO_EN, BUSY}, 0);
      reset = 1'b0;
      repeat (4) @(negedge CLK);
      for (int k = 0; k < 11; k++) begin
         if (k == 5) reset_mid_frame();
         apply(vecs[k], k);
      end
      check("strobes never overlap", n_both, 0);
      check("pulses one cycle wide", n_long, 0);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
